// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP input loader: FSM state encoding and default sizing.
package mlp_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/mlp_input_loader.sv
// Pulls one length-prefixed packet from an upstream valid/read stream and writes
// its payload words into a buffer at consecutive addresses starting from 0.
module mlp_input_loader
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  pi_mlp_data_valid,
  input  logic [DATA_WIDTH-1:0] pi_mlp_data,
  output logic                  po_data_read,
  input  logic                  pi_start,
  input  logic                  pi_abort,
  output logic                  po_buf_we,
  output logic [ADDR_WIDTH-1:0] po_buf_addr,
  output logic [DATA_WIDTH-1:0] po_buf_wdata,
  output logic                  po_busy,
  output logic                  po_done,
  output logic                  po_error,
  output logic [ADDR_WIDTH:0]   po_word_count
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                 state_q;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       word_count_q;
  logic                   buf_we_q;
  logic [ADDR_WIDTH-1:0]  buf_addr_q;
  logic [DATA_WIDTH-1:0]  buf_wdata_q;
  logic                   done_q;
  logic                   error_q;

  logic                   consume;
  logic [CNT_W-1:0]       hdr_len;
  logic [CNT_W-1:0]       word_count_d;

  // Abort wins over a simultaneous consume so the word on the bus stays upstream.
  assign consume      = pi_mlp_data_valid && !pi_abort &&
                        (state_q == ST_HEADER || state_q == ST_LOAD);
  assign hdr_len      = pi_mlp_data[ADDR_WIDTH:0];
  assign word_count_d = word_count_q + CNT_W'(1);

  assign po_data_read  = consume;
  assign po_busy       = (state_q == ST_HEADER) || (state_q == ST_LOAD);
  assign po_buf_we     = buf_we_q;
  assign po_buf_addr   = buf_addr_q;
  assign po_buf_wdata  = buf_wdata_q;
  assign po_done       = done_q;
  assign po_error      = error_q;
  assign po_word_count = word_count_q;

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;

      if (pi_abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pi_start) begin
              state_q      <= ST_HEADER;
              word_count_q <= '0;
            end
          end

          ST_HEADER: begin
            if (consume) begin
              len_q <= hdr_len;
              if (hdr_len == '0 || hdr_len > MAX_WORDS) state_q <= ST_ERR;
              else                                      state_q <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            if (consume) begin
              buf_we_q     <= 1'b1;
              buf_addr_q   <= word_count_q[ADDR_WIDTH-1:0];
              buf_wdata_q  <= pi_mlp_data;
              word_count_q <= word_count_d;
              if (word_count_d == len_q) state_q <= ST_DONE;
            end
          end

          // The completion pulse lands one cycle after the final buffer write.
          ST_DONE: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end

          ST_ERR: begin
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_input_loader.sv
// Directed + randomized bench for mlp_input_loader; expected buffer contents come
// from the packet definition (header length, payload queue), not from the RTL.
module tb_mlp_input_loader;

  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int MAXW = 1 << AW;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          rd;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   wcnt;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt, err_cnt, rd_cnt, last_we_cyc, done_cyc, timeouts;
  wr_t           wrq[$];
  logic [DW-1:0] wq[$];

  always #5 clk = ~clk;

  mlp_input_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .S_AXIS_ACLK      (clk),
    .S_AXIS_ARESETN   (rst_n),
    .pi_mlp_data_valid(valid),
    .pi_mlp_data      (data),
    .po_data_read     (rd),
    .pi_start         (start),
    .pi_abort         (abort),
    .po_buf_we        (we),
    .po_buf_addr      (addr),
    .po_buf_wdata     (wdata),
    .po_busy          (busy),
    .po_done          (done),
    .po_error         (err),
    .po_word_count    (wcnt)
  );

  // Observation of buffer writes and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (we) begin
      wrq.push_back('{a: addr, d: wdata});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
    if (rd)  rd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wrq.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    rd_cnt      = 0;
    last_we_cyc = -1;
    done_cyc    = -2;
    timeouts    = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word and hold it until the loader strobes read, bounded in time.
  task automatic send_word(input logic [DW-1:0] w, input int gap);
    int n;
    repeat (gap) tick();
    valid = 1'b1;
    data  = w;
    n     = 0;
    while (n < 50) begin
      @(negedge clk);
      if (rd) break;
      n++;
    end
    if (n >= 50) timeouts++;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic run_pkt(input logic [DW-1:0] hdr, input int n, input int gap_max,
                         input int abort_at, input bit start_mid);
    clear_mon();
    pulse_start();
    send_word(hdr, 0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        valid = 1'b1;
        data  = wq[i];
        abort = 1'b1;
        @(negedge clk);
        check("abort_blocks_read", rd, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        valid = 1'b0;
        break;
      end
      if (start_mid && i == 1) pulse_start();
      send_word(wq[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    end
    repeat (4) tick();
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    int mism;
    mism = 0;
    check({tag, "_nwrites"}, wrq.size(), n_exp);
    for (int i = 0; i < wrq.size() && i < n_exp; i++)
      if (wrq[i].a !== AW'(i) || wrq[i].d !== wq[i]) mism++;
    check({tag, "_contents"}, mism, 0);
  endtask

  initial begin
    int l;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_flags", {busy, we, done, err, rd}, 5'b0);
    check("rst_wcnt",  wcnt, 0);
    check("rst_bus",   {addr, wdata}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Valid high in IDLE must be ignored until start
    clear_mon();
    valid = 1'b1;
    data  = 32'd3;
    repeat (10) tick();
    check("idle_no_read", rd_cnt, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("hdr_read_after_start", rd, 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    wq = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) send_word(wq[i], 0);
    repeat (4) tick();
    check_writes("pkt3", 3);
    check("pkt3_done",      done_cnt, 1);
    check("pkt3_done_time", done_cyc, last_we_cyc + 1);
    check("pkt3_wcnt",      wcnt, 3);
    check("pkt3_idle",      busy, 1'b0);
    check("pkt3_timeouts",  timeouts, 0);

    // Illegal headers: zero length and one past the buffer size
    run_pkt(32'd0, 0, 0, -1, 0);
    check("hdr0_error",  err_cnt, 1);
    check("hdr0_writes", wrq.size(), 0);
    check("hdr0_done",   done_cnt, 0);
    check("hdr0_idle",   busy, 1'b0);
    run_pkt(32'd1025, 0, 0, -1, 0);
    check("hdr1025_error",  err_cnt, 1);
    check("hdr1025_writes", wrq.size(), 0);
    check("hdr1025_wcnt",   wcnt, 0);
    check("hdr1025_idle",   busy, 1'b0);

    // Full buffer, back-to-back words
    wq.delete();
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom);
    run_pkt(32'd1024, MAXW, 0, -1, 0);
    check_writes("full", MAXW);
    check("full_last_addr", (wrq.size() > 0) ? wrq[wrq.size()-1].a : 'x, MAXW - 1);
    check("full_done",      done_cnt, 1);
    check("full_wcnt",      wcnt, MAXW);
    check("full_timeouts",  timeouts, 0);

    // Abort after two payload words, coincident with valid
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back($urandom);
    run_pkt(32'd5, 5, 0, 2, 0);
    check_writes("abort", 2);
    check("abort_done",  done_cnt + err_cnt, 0);
    check("abort_idle",  busy, 1'b0);
    check("abort_reads", rd_cnt, 3);
    check("abort_wcnt",  wcnt, 2);

    // Abort with start in IDLE stays IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_start_idle", busy, 1'b0);
    tick();

    // Random packets: random length, upper header junk, gaps, ignored mid-load start
    for (int p = 0; p < 4; p++) begin
      l = $urandom_range(1, 20);
      wq.delete();
      for (int i = 0; i < l; i++) wq.push_back($urandom);
      run_pkt(($urandom << (AW + 1)) | DW'(l), l, 2, -1, l >= 2);
      check_writes($sformatf("rnd%0d", p), l);
      check($sformatf("rnd%0d_done", p), done_cnt, 1);
      check($sformatf("rnd%0d_wcnt", p), wcnt, l);
      check($sformatf("rnd%0d_timeouts", p), timeouts, 0);
    end

    // Asynchronous reset in the middle of a load
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    clear_mon();
    pulse_start();
    send_word(32'd8, 0);
    for (int i = 0; i < 3; i++) send_word(wq[i], 0);
    valid = 1'b1;
    data  = wq[3];
    check("pre_rst_we", we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {busy, we, done, err, rd}, 5'b0);
    check("rst_mid_wcnt",  wcnt, 0);
    check("rst_mid_bus",   {addr, wdata}, 0);
    tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (4) tick();
    check("rst_rel_pulses", done_cnt + err_cnt, 0);
    check("rst_rel_idle",   {busy, rd_cnt[0]}, 2'b0);
    check("rst_rel_reads",  rd_cnt, 0);
    valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
